// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle for uart_tx_arbiter.
// Requester i drives bits [8i+7:8i] of req_data; a byte moves on req_valid & req_ready.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    // Requesters drive the byte streams and observe ready.
    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    // The arbiter consumes the byte streams and returns ready.
    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Requesters win one byte at a time. A byte sent with last=0 locks the line
// to its owner until a last=1 byte arrives or the owner stays silent too long.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CLK_DIV      = 434,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    uart_tx_arbiter_if.slave           req,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       lock_timeout
);
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BW  = $clog2(CLK_DIV);
    localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state, state_nxt;
    logic [BW-1:0]  baud, baud_nxt;
    logic [2:0]     bit_idx, bit_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic [IDW-1:0] rr_ptr, rr_nxt;
    logic           lock, lock_nxt;
    logic [TW-1:0]  tcnt, tcnt_nxt;
    logic [IDW-1:0] grant_nxt;
    logic           txd_nxt;
    logic           busy_nxt;
    logic           lock_timeout_nxt;

    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [7:0]          win_data;
    logic                win_last;
    logic                owner_valid;
    logic                bit_tick;
    logic [NUM_REQ-1:0]  ready_c;

    // Increment a requester index, wrapping at NUM_REQ (any NUM_REQ, not just 2^n).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        if (32'(i) >= NUM_REQ - 1) begin
            return '0;
        end
        return i + IDW'(1);
    endfunction

    assign bit_tick    = (baud == BW'(CLK_DIV - 1));
    assign owner_valid = req.req_valid[grant_id];

    // Pick the winner: the owner while locked, else first valid from rr_ptr upward.
    always_comb begin
        int unsigned    sum;
        logic [IDW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = 0;
        cand      = '0;
        if (lock) begin
            win_found = owner_valid;
            win_idx   = grant_id;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                sum = 32'(rr_ptr) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                cand = IDW'(sum);
                if (!win_found && req.req_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Route the winner's byte/last and raise its ready bit only in IDLE.
    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        ready_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_data   = req.req_data[8*i +: 8];
                win_last   = req.req_last[i];
                ready_c[i] = (state == IDLE) && win_found;
            end
        end
    end

    // Nothing is accepted while reset is held.
    assign req.req_ready = ready_c & {NUM_REQ{reset}};

    // State register and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            baud         <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rr_ptr       <= '0;
            lock         <= 1'b0;
            tcnt         <= '0;
            grant_id     <= '0;
            txd          <= 1'b1;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            baud         <= baud_nxt;
            bit_idx      <= bit_nxt;
            shreg        <= shreg_nxt;
            rr_ptr       <= rr_nxt;
            lock         <= lock_nxt;
            tcnt         <= tcnt_nxt;
            grant_id     <= grant_nxt;
            txd          <= txd_nxt;
            busy         <= busy_nxt;
            lock_timeout <= lock_timeout_nxt;
        end
    end

    // Next state: accept/lock handling in IDLE, bit timing in the frame states.
    always_comb begin
        state_nxt        = state;
        baud_nxt         = baud + BW'(1);
        bit_nxt          = bit_idx;
        shreg_nxt        = shreg;
        rr_nxt           = rr_ptr;
        lock_nxt         = lock;
        tcnt_nxt         = '0;
        grant_nxt        = grant_id;
        lock_timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (win_found) begin
                    shreg_nxt = win_data;
                    grant_nxt = win_idx;
                    state_nxt = START;
                    if (win_last) begin
                        lock_nxt = 1'b0;
                        rr_nxt   = wrap_inc(win_idx);
                    end else begin
                        lock_nxt = 1'b1;
                    end
                end else if (lock && !owner_valid) begin
                    // Silent owner: count idle cycles, then hand the line back.
                    if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
                        lock_nxt         = 1'b0;
                        rr_nxt           = wrap_inc(grant_id);
                        lock_timeout_nxt = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    baud_nxt = '0;
                    bit_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_nxt = STOP;
                    baud_nxt  = '0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
            end
        endcase

        // Line level follows the state being entered so txd is a clean flop.
        txd_nxt = 1'b1;
        case (state_nxt)
            START:  txd_nxt = 1'b0;
            DATA:   txd_nxt = shreg_nxt[bit_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_nxt = ^shreg_nxt;
`endif
            default: txd_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// packet traffic, checked against a frame-level model of arbitration and line waveform.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned CDIV = 4;
    localparam int unsigned LT   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CDIV;

    logic clock = 1'b0;
    logic reset;
    logic txd;
    logic busy;
    logic grant_id;
    logic lock_timeout;

    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .CLK_DIV     (CDIV),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (bus.slave),
        .txd         (txd),
        .busy        (busy),
        .grant_id    (grant_id),
        .lock_timeout(lock_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: per-requester pending bytes {last, data}, round-robin pointer, lock.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] acc_q[$];
    int         m_rr    = 0;
    int         m_owner = 0;
    bit         m_lock  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected txd level for each clock cycle of one frame carrying b.
    function automatic logic [63:0] wave_of(input logic [7:0] b);
        logic [63:0] w;
        int          n;
        logic        v;
        w = '0;
        for (int c = 0; c < int'(FRAME); c++) begin
            n = c / int'(CDIV);
            if (n == 0)                       v = 1'b0;
            else if (n <= 8)                  v = b[n-1];
            else if (n == 9 && NBITS == 11)   v = ^b;
            else                              v = 1'b1;
            w[c] = v;
        end
        return w;
    endfunction

    // Who the arbiter should pick given the valid vector.
    function automatic int pick(input logic [1:0] v);
        int idx;
        if (m_lock) return m_owner;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (m_rr + k) % int'(NREQ);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Present the head of each requester queue (held until accepted).
    task automatic drive();
        bus.req_valid = {q1.size() > 0, q0.size() > 0};
        bus.req_last  = 2'b00;
        if (q0.size() > 0) begin
            bus.req_data[7:0] = q0[0][7:0];
            bus.req_last[0]   = q0[0][8];
        end
        if (q1.size() > 0) begin
            bus.req_data[15:8] = q1[0][7:0];
            bus.req_last[1]    = q1[0][8];
        end
        #1;
    endtask

    // Run queued traffic to completion; entered and left on an IDLE negedge.
    task automatic run_traffic(input string name);
        int          guard;
        int          w;
        logic [8:0]  item;
        logic [63:0] tw, bw, rw, exp_busy;
        guard    = 0;
        exp_busy = {64{1'b1}} >> (64 - FRAME);
        while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
            guard++;
            drive();
            chk({name, ":idle_busy"}, 64'(busy), 64'(0));
            if (m_lock && ((m_owner == 0) ? q0.size() == 0 : q1.size() == 0)) begin
                for (int c = 1; c <= int'(LT); c++) begin
                    chk({name, ":locked_ready"}, 64'(bus.req_ready), 64'(0));
                    chk({name, ":no_pulse"}, 64'(lock_timeout), 64'(0));
                    @(negedge clock);
                end
                chk({name, ":timeout_pulse"}, 64'(lock_timeout), 64'(1));
                m_lock = 1'b0;
                m_rr   = (m_owner + 1) % int'(NREQ);
            end
            w = pick(bus.req_valid);
            chk({name, ":ready"}, 64'(bus.req_ready), (w < 0) ? 64'(0) : (64'(1) << w));
            if (w < 0) break;
            item = (w == 0) ? q0.pop_front() : q1.pop_front();
            acc_q.push_back(item[7:0]);
            m_owner = w;
            if (item[8]) begin
                m_lock = 1'b0;
                m_rr   = (w + 1) % int'(NREQ);
            end else begin
                m_lock = 1'b1;
            end
            @(negedge clock);
            drive();
            chk({name, ":grant_id"}, 64'(grant_id), 64'(w));
            tw = '0;
            bw = '0;
            rw = '0;
            for (int c = 0; c < int'(FRAME); c++) begin
                tw[c] = txd;
                bw[c] = busy;
                rw[c] = |bus.req_ready;
                if (c < int'(FRAME) - 1) @(negedge clock);
            end
            @(negedge clock);
            chk({name, ":txd_wave"}, tw, wave_of(item[7:0]));
            chk({name, ":busy_wave"}, bw, exp_busy);
            chk({name, ":ready_in_frame"}, rw, 64'(0));
        end
        chk({name, ":guard"}, 64'(guard < 200), 64'(1));
    endtask

    task automatic chk_order(input string name, input logic [31:0] exp, input int n);
        chk({name, ":count"}, 64'(acc_q.size()), 64'(n));
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            chk({name, ":order"}, 64'(acc_q[i]), 64'(exp[8*(n-1-i) +: 8]));
        end
        acc_q.delete();
    endtask

    initial begin
        int total;
        int r, len;
        bit ab;

        // Reset with both requesters asserting valid.
        reset         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = 16'h2211;
        bus.req_last  = 2'b11;
        repeat (3) @(negedge clock);
        chk("rst:txd", 64'(txd), 64'(1));
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:grant_id", 64'(grant_id), 64'(0));
        chk("rst:lock_timeout", 64'(lock_timeout), 64'(0));
        chk("rst:ready", 64'(bus.req_ready), 64'(0));
        reset         = 1'b1;
        bus.req_valid = 2'b00;

        // Lock timeout: req0 leaves its packet open, req1 waits.
        q0.push_back(9'h055);
        q1.push_back(9'h166);
        run_traffic("timeout");
        chk_order("timeout", 32'h5566, 2);

        // Round-robin between two single-byte streams.
        q0.push_back(9'h111); q0.push_back(9'h111);
        q1.push_back(9'h122); q1.push_back(9'h122);
        run_traffic("rr");
        chk_order("rr", 32'h11221122, 4);

        // Packet lock keeps req1 out until req0's last byte.
        q0.push_back(9'h001); q0.push_back(9'h002); q0.push_back(9'h103);
        q1.push_back(9'h144);
        run_traffic("lock");
        chk_order("lock", 32'h01020344, 4);

        // Single bytes (parity 0 and 1 cases included).
        q0.push_back(9'h1A5); q0.push_back(9'h107); q0.push_back(9'h103);
        run_traffic("single");
        chk_order("single", 32'h00A50703, 3);

        // Reset during data bit 3 of 0xFF.
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h00FF;
        bus.req_last  = 2'b01;
        #1;
        chk("midrst:ready", 64'(bus.req_ready), 64'(1));
        @(negedge clock);
        bus.req_valid = 2'b00;
        repeat (17) @(negedge clock);
        chk("midrst:bit3", 64'(txd), 64'(1));
        chk("midrst:busy_before", 64'(busy), 64'(1));
        reset         = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clock);
        chk("midrst:txd", 64'(txd), 64'(1));
        chk("midrst:busy", 64'(busy), 64'(0));
        chk("midrst:ready", 64'(bus.req_ready), 64'(0));
        chk("midrst:grant_id", 64'(grant_id), 64'(0));
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        m_rr          = 0;
        m_lock        = 1'b0;
        m_owner       = 0;
        q0.push_back(9'h10F);
        run_traffic("postrst");
        chk_order("postrst", 32'h0000000F, 1);

        // Random packets, some left open to exercise the lock timeout.
        total = 0;
        for (int p = 0; p < 10; p++) begin
            r   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 3));
            ab  = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < len; j++) begin
                if (r == 0) q0.push_back({(j == len - 1) && !ab, 8'($urandom)});
                else        q1.push_back({(j == len - 1) && !ab, 8'($urandom)});
                total++;
            end
        end
        run_traffic("rand");
        chk("rand:count", 64'(acc_q.size()), 64'(total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line among NUM_REQ byte-stream requesters, e.g. core console and debug monitor, all driving the top-level UART txd pin.
- Round-robin arbitration per byte, with optional packet lock so multi-byte messages are not interleaved.
- Contains the 8N1 serializer and baud divider, so the transmit pin is driven directly from this block.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be >=2.
- LOCK_TIMEOUT, 1024, idle cycles a locked owner may withhold valid before the lock is force-released (>=1).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of a packet; releases the lock.
- req_ready  output  NUM_REQ  per-requester accept; handshake is valid&ready.
- txd  output  1  serial out; idle high.
- busy  output  1  frame in progress (state != IDLE).
- grant_id  output  clog2(NUM_REQ)  index of the last accepted requester.
- lock_timeout  output  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset (reset==0 at a rising edge) gives: txd=1, req_ready=0, busy=0, grant_id=0, lock_timeout=0, state=IDLE, rr_ptr=0, lock=0, timeout counter=0.
- Reset mid-frame aborts the frame; txd is 1 from the following cycle.
- FSM states are IDLE, START, DATA, STOP.
- Baud counter runs 0..CLK_DIV-1 in the non-IDLE states and is cleared on every state entry.
- Each bit is held exactly CLK_DIV cycles.
- Arbitration (combinational, IDLE only):
  - Unlocked: winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Locked: only the owner (grant_id) is eligible.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - req_ready is 0 in every non-IDLE state.
- Accept (handshake in IDLE):
  - Capture the byte into the shift register and grant_id <= winner.
  - Next state is START; txd=0 from the next cycle, so latency is 1 cycle from handshake to the start-bit edge.
  - If req_last=1: lock <= 0 and rr_ptr <= winner+1 (mod NUM_REQ).
  - If req_last=0: lock <= 1 and rr_ptr is unchanged.
- Frame sequence:
  - START is txd=0.
  - DATA sends 8 bits, LSB first, using a 3-bit bit index that wraps 7 -> STOP.
  - STOP is txd=1.
  - After STOP completes, return to IDLE.
  - A frame is 10*CLK_DIV cycles; back-to-back frames have exactly 1 IDLE cycle between stop end and the next start.
- Lock timeout:
  - The counter increments each IDLE cycle while lock=1 and the owner's valid is 0; it is cleared otherwise.
  - On reaching LOCK_TIMEOUT: lock <= 0, rr_ptr <= owner+1, and lock_timeout pulses for 1 cycle.
  - Arbitration in that same cycle still uses the old lock.
- Simultaneous events: valid asserted during a frame waits in IDLE; requesters must hold valid and data stable until ready.
- Width rules:
  - Counters are sized clog2(CLK_DIV) and clog2(LOCK_TIMEOUT+1).
  - rr_ptr wraps at NUM_REQ, including non-power-of-2 values.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP, with txd = XOR of the 8 data bits (even parity). The frame becomes 11*CLK_DIV cycles.
- When undefined: 8N1 with no PARITY state; frame is 10*CLK_DIV cycles.

Test Plan:
- Single byte: CLK_DIV=4; req0 sends 0xA5 with last=1 -> txd the cycle after handshake is 0,1,0,1,0,0,1,0,1,1 (start, b0..b7, stop), each held 4 cycles. busy is high for 40 cycles, then 1 IDLE cycle.
- Round-robin: NUM_REQ=2; both requesters valid continuously with last=1, req0 sends 0x11 and req1 sends 0x22 -> accepted order 0x11,0x22,0x11,0x22; grant_id alternates 0,1,0,1.
- Packet lock: req0 sends 0x01,0x02,0x03 (last on 0x03) while req1 holds 0x44 valid -> serial order 0x01,0x02,0x03,0x44; req_ready[1] stays 0 until 0x03 is accepted.
- Lock timeout: LOCK_TIMEOUT=8; req0 sends 0x55 with last=0 then drops valid; req1 is valid with 0x66 -> lock_timeout pulses after 8 IDLE cycles; 0x66 is accepted on the next cycle.
- Reset mid-frame: reset=0 during bit 3 of 0xFF -> txd=1, busy=0, and req_ready all 0 the next cycle. After release, a new byte 0x0F transmits correctly.
- Parity (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame is 44 cycles at CLK_DIV=4.
